// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
//   in_data   8  byte offered by the producer
//   in_valid  1  in_data is valid
//   in_ready  1  transmitter can take a byte this cycle
// master: producer side; slave: transmitter side.
interface uart_tx_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, no parity, 1 or 2 stop bits, LSB first.
// Bit timing comes from an internal counter of CLK_FREQ/BAUD_RATE clocks.
// A one-byte holding register lets the next frame start right after the
// last stop cycle of the current one.
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   in_bus   --   byte handshake (in_data, in_valid, in_ready)
//   tx       out  serial line, idle high, driven from a flop
//   busy     out  frame in progress
//   tx_done  out  one-cycle pulse during the last stop-bit cycle
//
// state   | meaning
// S_IDLE  | line idle (tx=1), waiting for a byte
// S_START | start bit (tx=0)
// S_DATA  | data bits, shift[0] on the line, bit_idx 0..7
// S_STOP  | stop bit(s) (tx=1), stop_idx 0..STOP_BITS-1
module uart_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   uart_tx_if.slave   in_bus,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
   logic [2:0]       bit_idx, bit_idx_d;
   logic             stop_idx, stop_idx_d;
   logic [7:0]       shift, shift_d;
   logic [7:0]       hold, hold_d;
   logic             hold_full, hold_full_d;
   logic             tx_d;
   logic             accept;
   logic             bit_end;
   logic             last_stop;

   assign accept    = in_bus.in_valid && !hold_full;
   assign bit_end   = (bit_cnt == CNT_MAX);
   assign last_stop = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);

   assign in_bus.in_ready = !hold_full;
   assign busy            = (state != S_IDLE);
   assign tx_done         = last_stop;

   always_comb begin
      state_d     = state;
      bit_cnt_d   = bit_end ? '0 : bit_cnt + CNT_W'(1);
      bit_idx_d   = bit_idx;
      stop_idx_d  = stop_idx;
      shift_d     = shift;
      hold_d      = hold;
      hold_full_d = hold_full;

      case (state)
         S_IDLE: begin
            bit_cnt_d  = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            // Idle accept goes straight to the shifter; hold stays empty.
            if (accept) begin
               shift_d = in_bus.in_data;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_d    = S_STOP;
                  stop_idx_d = 1'b0;
               end else begin
                  bit_idx_d = bit_idx + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (stop_idx == STOP_LAST) begin
                  // Chain the next frame with no idle cycle when a byte is waiting
                  // or arrives on this very edge.
                  if (hold_full) begin
                     shift_d     = hold;
                     hold_full_d = 1'b0;
                     state_d     = S_START;
                  end else if (accept) begin
                     shift_d = in_bus.in_data;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept && (state != S_IDLE) && !last_stop) begin
         hold_d      = in_bus.in_data;
         hold_full_d = 1'b1;
      end

      // tx is registered from the next-state view so the line changes on
      // the same edge the FSM does.
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         tx        <= 1'b1;
      end else begin
         state     <= state_d;
         bit_cnt   <= bit_cnt_d;
         bit_idx   <= bit_idx_d;
         stop_idx  <= stop_idx_d;
         shift     <= shift_d;
         hold      <= hold_d;
         hold_full <= hold_full_d;
         tx        <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) at 10 clocks per bit.
// A frame-level model predicts tx/busy/tx_done/in_ready every cycle; a line
// decoder recovers bytes from tx for order/loss checks.
module tb_uart_tx;
   localparam int CF  = 1000;
   localparam int BR  = 100;
   localparam int CPB = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_if if0 ();
   uart_tx_if if1 ();

   logic [7:0] d_in [2];
   logic       v_in [2];
   logic       rdy  [2];
   logic       txw  [2];
   logic       busyw[2];
   logic       donew[2];

   assign if0.in_data  = d_in[0];
   assign if0.in_valid = v_in[0];
   assign if1.in_data  = d_in[1];
   assign if1.in_valid = v_in[1];
   assign rdy[0] = if0.in_ready;
   assign rdy[1] = if1.in_ready;

   uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .in_bus(if0.slave),
      .tx(txw[0]), .busy(busyw[0]), .tx_done(donew[0]));

   uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .in_bus(if1.slave),
      .tx(txw[1]), .busy(busyw[1]), .tx_done(donew[1]));

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int flen(input int k);
      return (k == 0) ? 10 * CPB : 11 * CPB;
   endfunction

   // Frame-level model: position within the current frame and a list of waiting bytes.
   int         m_pos[2];
   logic [7:0] m_cur[2];
   logic [7:0] m_q  [2][4];
   int         m_qn [2];

   task automatic model_step(input int k);
      logic acc;
      acc = v_in[k] && (m_qn[k] == 0);
      if (rst) begin
         m_pos[k] = -1;
         m_qn[k]  = 0;
      end else if (m_pos[k] < 0) begin
         if (acc) begin
            m_cur[k] = d_in[k];
            m_pos[k] = 0;
         end
      end else if (m_pos[k] == flen(k) - 1) begin
         if (m_qn[k] > 0) begin
            m_cur[k] = m_q[k][0];
            for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
            m_qn[k]--;
            m_pos[k] = 0;
         end else if (acc) begin
            m_cur[k] = d_in[k];
            m_pos[k] = 0;
         end else begin
            m_pos[k] = -1;
         end
      end else begin
         m_pos[k]++;
         if (acc) begin
            m_q[k][m_qn[k]] = d_in[k];
            m_qn[k]++;
         end
      end
   endtask

   function automatic logic exp_tx(input int k);
      int b;
      if (m_pos[k] < 0) return 1'b1;
      b = m_pos[k] / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_cur[k][b-1];
      return 1'b1;
   endfunction

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_pos[k] = -1;
         m_qn[k]  = 0;
         m_cur[k] = '0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   // Line decoder and run statistics.
   logic       d_act [2];
   int         d_c   [2];
   logic [7:0] d_byte[2];
   logic       seq   [2][11];
   logic [7:0] rxlog [2][16];
   int         rxn   [2];
   int         busy_cnt[2];
   int         last_run[2];
   int         done_cnt[2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         d_act[k] = 1'b0; d_c[k] = 0; d_byte[k] = '0; rxn[k] = 0;
         busy_cnt[k] = 0; last_run[k] = 0; done_cnt[k] = 0;
      end
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("tx[%0d]", k), txw[k], exp_tx(k));
               chk($sformatf("busy[%0d]", k), busyw[k], m_pos[k] >= 0);
               chk($sformatf("tx_done[%0d]", k), donew[k], m_pos[k] == flen(k) - 1);
               chk($sformatf("in_ready[%0d]", k), rdy[k], m_qn[k] == 0);

               if (busyw[k] === 1'b1) busy_cnt[k]++;
               else if (busy_cnt[k] != 0) begin
                  last_run[k] = busy_cnt[k];
                  busy_cnt[k] = 0;
               end
               if (donew[k] === 1'b1) done_cnt[k]++;

               if (rst) d_act[k] = 1'b0;
               else if (!d_act[k]) begin
                  if (txw[k] === 1'b0) begin
                     d_act[k] = 1'b1;
                     d_c[k]   = 0;
                  end
               end else d_c[k]++;

               if (d_act[k] && !rst) begin
                  if (d_c[k] % CPB == CPB / 2) begin
                     int b;
                     b = d_c[k] / CPB;
                     seq[k][b] = txw[k];
                     if (b == 0) chk($sformatf("start_bit[%0d]", k), txw[k], 0);
                     else if (b <= 8) d_byte[k][b-1] = txw[k];
                     else chk($sformatf("stop_bit[%0d]", k), txw[k], 1);
                  end
                  if (d_c[k] == flen(k) - 1) begin
                     if (rxn[k] < 16) rxlog[k][rxn[k]] = d_byte[k];
                     rxn[k]++;
                     d_act[k] = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic send(input int k, input logic [7:0] b, output int acc_cyc);
      logic r;
      logic ok;
      ok = 1'b0;
      d_in[k] = b;
      v_in[k] = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         r = rdy[k];
         @(posedge clk);
         #1;
         if (r === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      acc_cyc = cyc;
      chk("send_accepted", ok, 1);
      v_in[k] = 1'b0;
      d_in[k] = 8'($urandom);
   endtask

   // Waits for busy to drop while scrambling in_data with in_valid low.
   task automatic wait_idle(input int k);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         d_in[k] = 8'($urandom);
         if (busyw[k] === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_idle", ok, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats(input int k);
      rxn[k] = 0;
      done_cnt[k] = 0;
   endtask

   logic [9:0] seq_got;
   int ta, tb, tc;

   initial begin
      v_in[0] = 1'b0; v_in[1] = 1'b0;
      d_in[0] = 8'h00; d_in[1] = 8'h00;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_tx", txw[k], 1);
         chk("reset_busy", busyw[k], 0);
         chk("reset_in_ready", rdy[k], 1);
         chk("reset_tx_done", donew[k], 0);
      end
      @(posedge clk); #1;

      // single byte
      clear_stats(0);
      send(0, 8'h41, ta);
      @(negedge clk);
      chk("t1_tx_low_after_accept", txw[0], 0);
      wait_idle(0);
      for (int b = 0; b < 10; b++) seq_got[9-b] = seq[0][b];
      chk("t1_mid_bit_samples", seq_got, 10'b0100000101);
      chk("t1_frame_len", last_run[0], 100);
      chk("t1_done_pulses", done_cnt[0], 1);
      chk("t1_rx_count", rxn[0], 1);
      chk("t1_rx_byte", rxlog[0][0], 8'h41);
      chk("t1_busy_after", busyw[0], 0);

      // back-to-back with in_valid held
      clear_stats(0);
      send(0, 8'h61, ta);
      send(0, 8'h41, tb);
      chk("t2_second_accept_cycle", tb - ta, 1);
      wait_idle(0);
      chk("t2_total_len", last_run[0], 200);
      chk("t2_done_pulses", done_cnt[0], 2);
      chk("t2_rx_count", rxn[0], 2);
      chk("t2_rx0", rxlog[0][0], 8'h61);
      chk("t2_rx1", rxlog[0][1], 8'h41);

      // three bytes, third stalls until frame 2 loads
      clear_stats(0);
      send(0, 8'h11, ta);
      send(0, 8'h22, tb);
      send(0, 8'h33, tc);
      chk("t3_b_accept", tb - ta, 1);
      chk("t3_c_stall", tc - ta, 101);
      wait_idle(0);
      chk("t3_total_len", last_run[0], 300);
      chk("t3_done_pulses", done_cnt[0], 3);
      chk("t3_rx_count", rxn[0], 3);
      chk("t3_rx0", rxlog[0][0], 8'h11);
      chk("t3_rx1", rxlog[0][1], 8'h22);
      chk("t3_rx2", rxlog[0][2], 8'h33);

      // reset mid-DATA
      clear_stats(0);
      send(0, 8'hAA, ta);
      repeat (35) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t4_tx_after_rst", txw[0], 1);
      chk("t4_busy_after_rst", busyw[0], 0);
      chk("t4_ready_after_rst", rdy[0], 1);
      @(posedge clk); #1;
      send(0, 8'h55, ta);
      wait_idle(0);
      chk("t4_rx_count", rxn[0], 1);
      chk("t4_rx_byte", rxlog[0][0], 8'h55);
      chk("t4_frame_len", last_run[0], 100);

      // two stop bits
      clear_stats(1);
      send(1, 8'hFF, ta);
      wait_idle(1);
      chk("t5_frame_len", last_run[1], 110);
      chk("t5_done_pulses", done_cnt[1], 1);
      chk("t5_rx_count", rxn[1], 1);
      chk("t5_rx_byte", rxlog[1][0], 8'hFF);

      // in_valid while in_ready=0 must be ignored
      clear_stats(0);
      send(0, 8'h5A, ta);
      send(0, 8'hA5, tb);
      repeat (10) @(posedge clk);
      #1;
      chk("t6_ready_low", rdy[0], 0);
      for (int i = 0; i < 4; i++) begin
         v_in[0] = 1'b1;
         d_in[0] = 8'hEE ^ 8'(i);
         @(posedge clk); #1;
      end
      v_in[0] = 1'b0;
      wait_idle(0);
      chk("t6_rx_count", rxn[0], 2);
      chk("t6_rx0", rxlog[0][0], 8'h5A);
      chk("t6_rx1", rxlog[0][1], 8'hA5);
      chk("t6_done_pulses", done_cnt[0], 2);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule
